// File: rtl/stepper_motion_sequencer.sv
// Single-axis stepper move sequencer. Accepts a step-count/direction command,
// emits step pulses on a trapezoidal (or triangular) period profile with one
// period update per step, pulses done on completion, and aborts on estop.
module stepper_motion_sequencer #(
  parameter int STEP_W     = 32,
  parameter int PER_W      = 16,
  parameter int MAX_PERIOD = 100,
  parameter int MIN_PERIOD = 40,
  parameter int ACCEL_DEC  = 20,
  parameter int PULSE_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              estop,
  output logic              step_out,
  output logic              dir_out,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [STEP_W-1:0] steps_done
);

  localparam logic [PER_W-1:0]  MAX_P    = PER_W'(MAX_PERIOD);
  localparam logic [PER_W-1:0]  MIN_P    = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0]  DEC_P    = PER_W'(ACCEL_DEC);
  localparam logic [PER_W-1:0]  PULSE_P  = PER_W'(PULSE_W);
  localparam logic [PER_W-1:0]  PER_ONE  = PER_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PER_W-1:0]  period_q, period_d;
  logic [PER_W-1:0]  cyc_q, cyc_d;
  logic [PER_W-1:0]  ramp_q, ramp_d;
  logic [STEP_W-1:0] n_q, n_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              dir_q, dir_d;
  logic              fault_q, fault_d;
  logic              step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [STEP_W-1:0] steps_inc;
  logic [STEP_W-1:0] remaining;
  logic [PER_W-1:0]  ramp_inc;
  logic [PER_W-1:0]  rem_short;
  logic [PER_W-1:0]  decel_start;
  logic [PER_W-1:0]  period_up;
  logic [PER_W-1:0]  period_dn;
  logic              step_end;
  logic              moving_d;

  assign cmd_ready = (state_q == S_IDLE) && !estop;

  // Step-boundary arithmetic: steps left after the current step and candidate periods.
  always_comb begin
    steps_inc   = steps_q + STEP_ONE;
    remaining   = n_q - steps_inc;
    ramp_inc    = ramp_q + PER_ONE;
    // The decel entry point is only taken when remaining <= ramp count, which
    // is small, so the truncated copy is exact whenever it is used.
    rem_short   = PER_W'(remaining);
    decel_start = MAX_P - (rem_short - PER_ONE) * DEC_P;
    period_up   = period_q + DEC_P;
    period_dn   = period_q - DEC_P;
    step_end    = (cyc_q == period_q - PER_ONE);
  end

  // Next-state and next-output logic for the move sequencer.
  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    period_d = period_q;
    cyc_d    = cyc_q;
    ramp_d   = ramp_q;
    n_d      = n_q;
    steps_d  = steps_q;
    dir_d    = dir_q;
    fault_d  = fault_q;

    if (estop) begin
      // Abort: stop pulsing immediately, keep progress and direction frozen.
      state_d = S_IDLE;
      cyc_d   = '0;
      if (state_q != S_IDLE) fault_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            n_d      = cmd_steps;
            dir_d    = cmd_dir;
            steps_d  = '0;
            fault_d  = 1'b0;
            period_d = MAX_P;
            ramp_d   = '0;
            cyc_d    = '0;
            state_d  = (cmd_steps == '0) ? S_DONE : S_ACCEL;
          end
        end

        S_ACCEL, S_CRUISE, S_DECEL: begin
          if (step_end) begin
            steps_d = steps_inc;
            cyc_d   = '0;
            if (remaining == '0) begin
              state_d = S_DONE;
            end else begin
              case (state_q)
                S_ACCEL: begin
                  ramp_d = ramp_inc;
                  if (remaining <= STEP_W'(ramp_inc)) begin
                    state_d  = S_DECEL;
                    period_d = decel_start;
                  end else begin
                    period_d = period_dn;
                    if (period_dn == MIN_P) state_d = S_CRUISE;
                  end
                end
                S_CRUISE: begin
                  if (remaining <= STEP_W'(ramp_q)) begin
                    state_d  = S_DECEL;
                    period_d = period_up;
                  end
                end
                default: begin
                  period_d = (period_up > MAX_P) ? MAX_P : period_up;
                end
              endcase
            end
          end else begin
            cyc_d = cyc_q + PER_ONE;
          end
        end

        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    moving_d = (state_d == S_ACCEL) || (state_d == S_CRUISE) || (state_d == S_DECEL);
    step_d   = moving_d && (cyc_d < PULSE_P);
    busy_d   = moving_d;
    done_d   = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge.
    if (reset) begin
      state_q  <= S_IDLE;
      period_q <= MAX_P;
      cyc_q    <= '0;
      ramp_q   <= '0;
      n_q      <= '0;
      steps_q  <= '0;
      dir_q    <= 1'b0;
      fault_q  <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cyc_q    <= cyc_d;
      ramp_q   <= ramp_d;
      n_q      <= n_d;
      steps_q  <= steps_d;
      dir_q    <= dir_d;
      fault_q  <= fault_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign step_out   = step_q;
  assign dir_out    = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign steps_done = steps_q;

endmodule

// File: tb/tb_stepper_motion_sequencer.sv
// Directed bench for stepper_motion_sequencer. Expected step periods are
// queued when a command is issued and popped as the monitor measures each step.
module tb_stepper_motion_sequencer;

  localparam int STEP_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic              estop;
  logic              step_out;
  logic              dir_out;
  logic              busy;
  logic              done;
  logic              fault;
  logic [STEP_W-1:0] steps_done;

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int acc_cyc   = 0;
  int exp_q[$];
  int last_rise = 0;
  bit have_rise = 1'b0;
  int hi_cnt    = 0;
  int rise_cnt  = 0;
  int done_cnt  = 0;
  logic prev_step = 1'b0;

  stepper_motion_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .estop      (estop),
    .step_out   (step_out),
    .dir_out    (dir_out),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .steps_done (steps_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic sb_compare(input string tag, input int obs);
    int e = -1;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check(tag, obs, e);
  endtask

  // Monitor: measures step periods (rise to rise, last step rise to done) and pulse width.
  always @(negedge clk) begin
    if (step_out && !prev_step) begin
      rise_cnt++;
      if (have_rise) sb_compare("step period", cyc - last_rise);
      last_rise = cyc;
      have_rise = 1'b1;
    end
    if (step_out) hi_cnt++;
    else if (prev_step) begin
      check("pulse width", hi_cnt, 10);
      hi_cnt = 0;
    end
    if (done) begin
      done_cnt++;
      if (have_rise) begin
        sb_compare("last step period", cyc - last_rise);
        have_rise = 1'b0;
      end
    end
    prev_step = step_out;
  end

  task automatic flush_sb();
    exp_q.delete();
    have_rise = 1'b0;
  endtask

  task automatic send_cmd(input int n, input bit d);
    @(negedge clk);
    check($sformatf("N=%0d ready before accept", n), cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_steps = STEP_W'(n);
    cmd_dir   = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!done && i < budget);
    check("done seen", done, 1);
    dcyc = cyc;
  endtask

  task automatic run_move(input int n, input bit d, input int total);
    int rc0 = rise_cnt;
    int dc0 = done_cnt;
    int dcyc;
    send_cmd(n, d);
    @(negedge clk);
    check($sformatf("N=%0d first pulse", n), step_out, 1);
    check($sformatf("N=%0d busy", n), busy, 1);
    check($sformatf("N=%0d ready while busy", n), cmd_ready, 0);
    check($sformatf("N=%0d dir_out", n), dir_out, d);
    check($sformatf("N=%0d fault cleared", n), fault, 0);
    wait_done(total + 50, dcyc);
    check($sformatf("N=%0d done cycle", n), dcyc - acc_cyc, total);
    check($sformatf("N=%0d steps_done", n), steps_done, n);
    check($sformatf("N=%0d busy at done", n), busy, 0);
    @(negedge clk);
    #1;
    check($sformatf("N=%0d done one cycle", n), done, 0);
    check($sformatf("N=%0d ready after", n), cmd_ready, 1);
    check($sformatf("N=%0d rises", n), rise_cnt - rc0, n);
    check($sformatf("N=%0d done pulses", n), done_cnt - dc0, 1);
    check($sformatf("N=%0d scoreboard empty", n), exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcyc;
    int rc0;
    int dc0;
    int acc2;

    reset = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0; estop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset step_out", step_out, 0);
    check("reset dir_out", dir_out, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset fault", fault, 0);
    check("reset steps_done", steps_done, 0);
    check("reset cmd_ready", cmd_ready, 1);
    reset = 1'b0;

    // Full trapezoid, triangle, and short triangle.
    exp_q = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
    run_move(10, 1'b1, 640);
    exp_q = '{100, 80, 60, 80, 100};
    run_move(5, 1'b0, 420);
    exp_q = '{100, 80, 80, 100};
    run_move(4, 1'b1, 360);

    // Zero-step command: straight to DONE, no pulses.
    rc0 = rise_cnt;
    dc0 = done_cnt;
    send_cmd(0, 1'b0);
    @(negedge clk);
    check("N=0 ready low", cmd_ready, 0);
    check("N=0 done", done, 1);
    check("N=0 busy", busy, 0);
    check("N=0 step_out", step_out, 0);
    check("N=0 steps_done", steps_done, 0);
    @(negedge clk);
    #1;
    check("N=0 ready back", cmd_ready, 1);
    check("N=0 done cleared", done, 0);
    check("N=0 no rises", rise_cnt - rc0, 0);
    check("N=0 done pulses", done_cnt - dc0, 1);

    // Emergency stop during step 5 (cycles 280..319 of the move).
    exp_q = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
    rc0 = rise_cnt;
    dc0 = done_cnt;
    send_cmd(10, 1'b1);
    while (cyc < acc_cyc + 290) @(negedge clk);
    estop = 1'b1;
    @(negedge clk);
    check("estop step_out", step_out, 0);
    check("estop fault", fault, 1);
    check("estop busy", busy, 0);
    check("estop steps_done", steps_done, 4);
    check("estop no done", done, 0);
    check("estop ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_steps = STEP_W'(3);
    repeat (5) @(negedge clk);
    check("estop cmd ignored busy", busy, 0);
    check("estop cmd ignored ready", cmd_ready, 0);
    check("estop fault held", fault, 1);
    check("estop steps frozen", steps_done, 4);
    check("estop rises", rise_cnt - rc0, 5);
    check("estop done pulses", done_cnt - dc0, 0);
    cmd_valid = 1'b0;
    estop = 1'b0;
    flush_sb();
    @(negedge clk);
    check("post-estop ready", cmd_ready, 1);
    check("post-estop fault sticky", fault, 1);
    exp_q = '{100, 100};
    run_move(2, 1'b0, 200);

    // Reset during CRUISE (step 5), then a single-step move.
    exp_q = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
    send_cmd(10, 1'b1);
    while (cyc < acc_cyc + 300) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset step_out", step_out, 0);
    check("midreset dir_out", dir_out, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset fault", fault, 0);
    check("midreset steps_done", steps_done, 0);
    check("midreset cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    flush_sb();
    exp_q = '{100};
    run_move(1, 1'b1, 100);

    // Command held valid while busy with different contents: ignored until IDLE.
    exp_q = '{100, 80, 80, 100, 100, 80, 60, 40, 60, 80, 100};
    dc0 = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_steps = STEP_W'(4);
    cmd_dir   = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_steps = STEP_W'(7);
    cmd_dir   = 1'b0;
    @(negedge clk);
    check("held busy", busy, 1);
    check("held dir kept", dir_out, 1);
    wait_done(500, dcyc);
    check("held first done cycle", dcyc - acc_cyc, 360);
    check("held first steps_done", steps_done, 4);
    check("held first dir_out", dir_out, 1);
    @(negedge clk);
    check("held idle ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc2 = cyc;
    @(negedge clk);
    check("second move pulse", step_out, 1);
    check("second move dir", dir_out, 0);
    check("second move steps cleared", steps_done, 0);
    wait_done(700, dcyc);
    check("second done cycle", dcyc - acc2, 520);
    check("second steps_done", steps_done, 7);
    @(negedge clk);
    #1;
    check("held done pulses", done_cnt - dc0, 2);
    check("held scoreboard empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stepper_motion_sequencer.md
Name: stepper_motion_sequencer

Overview:
- Sequences a single stepper axis through a complete move: accepts a step-count/direction command, emits step pulses on a trapezoidal (or triangular) speed profile, then reports completion.
- Acceleration, cruise and deceleration are sequenced from a period register, one update per step.
- Sits between the motion command source and the stepper driver pins.
- Has an emergency abort path.

Parameters:
- STEP_W, 32, width of step count and progress counter.
- PER_W, 16, width of period and cycle counters.
- MAX_PERIOD, 100, step period in clk cycles at start and end of a move.
- MIN_PERIOD, 40, cruise step period in clk cycles.
- ACCEL_DEC, 20, period change per step during ramps.
- PULSE_W, 10, step_out high time in clk cycles.
- Legal configuration: PULSE_W < MIN_PERIOD ≤ MAX_PERIOD, and (MAX_PERIOD−MIN_PERIOD) divisible by ACCEL_DEC. Other settings are unsupported.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  move command present.
- cmd_ready  out  1  command accepted on cmd_valid&&cmd_ready.
- cmd_steps  in  STEP_W  steps to move.
- cmd_dir  in  1  direction.
- estop  in  1  emergency stop, level sensitive.
- step_out  out  1  registered step pulse to driver.
- dir_out  out  1  registered direction to driver.
- busy  out  1  move in progress.
- done  out  1  one-cycle pulse on normal completion.
- fault  out  1  sticky abort flag.
- steps_done  out  STEP_W  steps completed in current/last move.

Behaviour:
- Reset values: step_out=0, dir_out=0, busy=0, done=0, fault=0, steps_done=0, cmd_ready=1 (when estop=0). Internal state is IDLE, period=MAX_PERIOD, ramp_cnt=0. Reset mid-move takes effect at the next edge with no further pulses.
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- cmd_ready = (state==IDLE) && !estop (combinational).
- Accept in IDLE:
  - Latch cmd_steps as N and cmd_dir into dir_out.
  - Clear steps_done and fault; period=MAX_PERIOD; ramp_cnt=0; cycle counter=0.
  - If N==0: go to DONE, no pulses.
  - Else: go to ACCEL, busy=1.
- Step timing: cycle counter runs 0..period−1.
  - step_out=1 while counter<PULSE_W, 0 otherwise.
  - First step_out high is the cycle after acceptance.
- At each step end (counter==period−1): steps_done++, counter←0, r=N−steps_done (new value). Then, by state:
  - ACCEL: ramp_cnt++. If r==0, go DONE. Else if r≤ramp_cnt, go DECEL with period=MAX_PERIOD−(r−1)*ACCEL_DEC. Else period−=ACCEL_DEC, and if the result equals MIN_PERIOD go CRUISE.
  - CRUISE: if r==0, go DONE. Else if r≤ramp_cnt, go DECEL with period+=ACCEL_DEC.
  - DECEL: if r==0, go DONE. Else period=min(period+ACCEL_DEC, MAX_PERIOD).
- DONE: one cycle; done=1, busy=0, step_out=0; next state IDLE. dir_out and steps_done hold until the next accept.
- estop=1 in any state:
  - Next edge: state IDLE, step_out=0, busy=0, fault=1, no done pulse, steps_done frozen.
  - No command is accepted while estop=1.
  - fault clears only on the next accepted command.
  - Simultaneous estop and cmd_valid in IDLE: not accepted; fault unchanged.
- cmd_valid outside IDLE is ignored; the command is not queued.
- steps_done wraps never: N≤2^STEP_W−1, and the counter stops at N.

Test Plan:
- Default params, N=10, dir=1 → step periods exactly 100,80,60,40,40,40,40,60,80,100 cycles; 10 rising edges of step_out, each high 10 cycles; dir_out=1; done pulses once, in the cycle after the 640th cycle of stepping; steps_done=10.
- N=5 → periods 100,80,60,80,100 (triangle, CRUISE never entered). N=4 → periods 100,80,80,100.
- N=0 → cmd_ready low one cycle, done pulses the cycle after accept, no step_out activity, steps_done=0.
- N=10 with estop asserted during step 5 → step_out low the next cycle, fault=1, busy=0, steps_done=4, no done; cmd_ready=0 until estop released; next accept clears fault.
- reset asserted during CRUISE → all outputs at reset values after one edge; a new N=1 command then yields a single 100-cycle step and done.
- cmd_valid held high while busy with a different cmd_steps → ignored; only the first move runs; new command accepted in IDLE after done.
